// File: rtl/uart_rx_core_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core_param
// Description : Parametrised UART receiver. Synchronises the rx pin, times
//               each bit from a runtime prescale, takes a 3-sample majority
//               vote per bit, deserialises LSB-first, checks optional
//               even/odd parity and 1 or 2 stop bits, and issues one-cycle
//               result strobes at frame end.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core_param #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rx_in,
  input  logic [PRESC_W-1:0] prescale_in,
  input  logic               par_en_in,
  input  logic               par_odd_in,
  input  logic               stop2_in,
  output logic [DATA_W-1:0]  rx_data_out,
  output logic               rx_valid_out,
  output logic               par_err_out,
  output logic               stp_err_out,
  output logic               busy_out
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [PRESC_W-1:0] C_ONE      = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] C_TWO      = PRESC_W'(2);
  localparam logic [PRESC_W-1:0] C_MIN_P    = PRESC_W'(8);
  localparam logic [CNT_W-1:0]   C_LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]   C_CNT_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_BRK_WAIT = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rx_meta;
  logic                r_rxs;
  logic [PRESC_W-1:0]  r_presc;
  logic                r_par_en;
  logic                r_par_odd;
  logic                r_stop2;
  logic [PRESC_W-1:0]  r_edge_cnt;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [2:0]          r_smp;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par_bad;

  logic [PRESC_W-1:0]  w_presc_eff;
  logic [PRESC_W-1:0]  w_half;
  logic [PRESC_W-1:0]  w_last;
  logic                w_edge_last;
  logic                w_spt_hit;
  logic                w_bit;
  logic                w_frame_end;
  logic                w_stop_bad;
  logic                w_cfg_load;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx_in;
      r_rxs     <= r_rx_meta;
    end
  end

  // Clamp prescale to at least 8 and drop bit0 so half-bit math stays exact.
  always_comb begin
    w_presc_eff = {prescale_in[PRESC_W-1:1], 1'b0};
    if (prescale_in < C_MIN_P) begin
      w_presc_eff = C_MIN_P;
    end
  end

  assign w_half      = {1'b0, r_presc[PRESC_W-1:1]};
  assign w_last      = r_presc - C_ONE;
  assign w_edge_last = (r_edge_cnt == w_last);
  assign w_spt_hit   = (r_edge_cnt == (w_half + C_TWO));
  assign w_bit       = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);
  assign w_cfg_load  = (r_state == S_IDLE) && !r_rxs;
  assign busy_out    = (r_state != S_IDLE);

  // Configuration is captured only as a frame starts so mid-frame changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc   <= C_MIN_P;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_stop2   <= 1'b0;
    end else if (w_cfg_load) begin
      r_presc   <= w_presc_eff;
      r_par_en  <= par_en_in;
      r_par_odd <= par_odd_in;
      r_stop2   <= stop2_in;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus frame-end / stop-error detection at sample points.
  always_comb begin
    w_state_nxt = r_state;
    w_frame_end = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rxs) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_spt_hit && w_bit) begin
          w_state_nxt = S_IDLE;
        end else if (w_edge_last) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_edge_last && (r_bit_cnt == C_LAST_BIT)) begin
          w_state_nxt = r_par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_edge_last) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_spt_hit) begin
          if (!w_bit) begin
            w_stop_bad  = 1'b1;
            w_frame_end = 1'b1;
            w_state_nxt = S_BRK_WAIT;
          end else if (!(r_stop2 && (r_bit_cnt == C_CNT_ZERO))) begin
            // Leave at mid-bit so a back-to-back start edge is not missed.
            w_frame_end = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_BRK_WAIT: begin
        if (r_rxs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Bit timing: edge_cnt runs 0..P-1 within a bit, bit_cnt counts bits within a state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if ((r_state == S_IDLE) || (w_state_nxt != r_state)) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_edge_last) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= r_bit_cnt + 1'b1;
    end else begin
      r_edge_cnt <= r_edge_cnt + C_ONE;
    end
  end

  // Capture the three vote samples around mid-bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_smp <= 3'b111;
    end else begin
      if (r_edge_cnt == (w_half - C_ONE)) r_smp[0] <= r_rxs;
      if (r_edge_cnt == w_half)           r_smp[1] <= r_rxs;
      if (r_edge_cnt == (w_half + C_ONE)) r_smp[2] <= r_rxs;
    end
  end

  // Deserialise LSB-first and evaluate parity against the received data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift   <= '0;
      r_par_bad <= 1'b0;
    end else begin
      if ((r_state == S_DATA) && w_spt_hit) begin
        r_shift <= {w_bit, r_shift[DATA_W-1:1]};
      end
      if (r_state == S_IDLE) begin
        r_par_bad <= 1'b0;
      end else if ((r_state == S_PARITY) && w_spt_hit) begin
        r_par_bad <= (w_bit != ((^r_shift) ^ r_par_odd));
      end
    end
  end

  // Registered result strobes; data only updates on a clean frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data_out  <= '0;
      rx_valid_out <= 1'b0;
      par_err_out  <= 1'b0;
      stp_err_out  <= 1'b0;
    end else begin
      rx_valid_out <= w_frame_end && !w_stop_bad && !r_par_bad;
      par_err_out  <= w_frame_end && r_par_bad;
      stp_err_out  <= w_frame_end && w_stop_bad;
      if (w_frame_end && !w_stop_bad && !r_par_bad) begin
        rx_data_out <= r_shift;
      end
    end
  end

endmodule
`default_nettype wire
